cpu_run_controller: RTL

- Hardware run sequencer for the single-cycle CPU (`singlecycle`).
- Holds the core in reset while the start PC is applied, then releases it and gates its execution through a clock-enable.
- Stops the core when currentpc reaches a programmed end address or when a cycle watchdog expires.
- Captures MemtoRegOut, compares it with an expected value and reports done/pass/timeout. Replaces bench-side PC polling, so programs can be sequenced on-chip.

---
 rtl/cpu_run_controller_if.sv | 49 ++++
 rtl/cpu_run_controller.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cpu_run_controller_if.sv
// Host/CPU-facing signal bundle for cpu_run_controller.
// The step_mode/step pair exists only when CPU_RUN_STEP_EN is defined.
interface cpu_run_controller_if #(
   parameter int PC_WIDTH   = 64,
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 16
);
   logic                  start;
   logic                  abort;
   logic [PC_WIDTH-1:0]   start_addr;
   logic [PC_WIDTH-1:0]   end_addr;
   logic [DATA_WIDTH-1:0] expected;
   logic [CNT_WIDTH-1:0]  max_cycles;
   logic [PC_WIDTH-1:0]   currentpc;
   logic [DATA_WIDTH-1:0] memtoregout;
`ifdef CPU_RUN_STEP_EN
   logic                  step_mode;
   logic                  step;
`endif
   logic                  cpu_resetl;
   logic [PC_WIDTH-1:0]   cpu_startpc;
   logic                  cpu_ce;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic                  timeout;
   logic [DATA_WIDTH-1:0] result;
   logic [CNT_WIDTH-1:0]  cycle_count;

   modport master (
      output start, abort, start_addr, end_addr, expected, max_cycles,
             currentpc, memtoregout,
`ifdef CPU_RUN_STEP_EN
             step_mode, step,
`endif
      input  cpu_resetl, cpu_startpc, cpu_ce, busy, done, pass, timeout,
             result, cycle_count
   );

   modport slave (
      input  start, abort, start_addr, end_addr, expected, max_cycles,
             currentpc, memtoregout,
`ifdef CPU_RUN_STEP_EN
             step_mode, step,
`endif
      output cpu_resetl, cpu_startpc, cpu_ce, busy, done, pass, timeout,
             result, cycle_count
   );
endinterface

// File: rtl/cpu_run_controller.sv
// Run sequencer for the single-cycle CPU: reset hold, gated run, end-PC/watchdog stop, result check.
// Optional single-step gating is enabled by defining CPU_RUN_STEP_EN.
module cpu_run_controller #(
   parameter int PC_WIDTH     = 64,
   parameter int DATA_WIDTH   = 64,
   parameter int CNT_WIDTH    = 16,
   parameter int RESET_CYCLES = 2
) (
   input logic                 CLK,
   input logic                 reset,
   cpu_run_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

   state_t                state_q;
   logic [HW-1:0]         hold_q;
   logic [PC_WIDTH-1:0]   end_q;
   logic [PC_WIDTH-1:0]   startpc_q;
   logic [DATA_WIDTH-1:0] exp_q;
   logic [CNT_WIDTH-1:0]  max_q;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  resetl_q, busy_q, done_q, pass_q, timeout_q;
   logic                  reached, wd_hit, step_ok, ce;

   assign reached = bus.currentpc >= end_q;
   assign wd_hit  = (max_q != '0) && (cnt_q == max_q);

`ifdef CPU_RUN_STEP_EN
   logic armed_q;
   assign step_ok = !bus.step_mode || armed_q;

   // One-shot: a step pulse in RUN grants exactly one enabled cycle.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)                           armed_q <= 1'b0;
      else if (state_q != RUN || bus.abort) armed_q <= 1'b0;
      else if (bus.step)                   armed_q <= 1'b1;
      else if (ce && bus.step_mode)        armed_q <= 1'b0;
   end
`else
   assign step_ok = 1'b1;
`endif

   // Combinational so the PC freezes in the same cycle the stop is detected.
   assign ce    = (state_q == RUN) && !reached && !wd_hit && step_ok;
   assign cnt_d = (ce && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         end_q     <= '0;
         startpc_q <= '0;
         exp_q     <= '0;
         max_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         resetl_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else if (bus.abort) begin
         state_q   <= IDLE;
         resetl_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  end_q     <= bus.end_addr;
                  exp_q     <= bus.expected;
                  max_q     <= bus.max_cycles;
                  startpc_q <= bus.start_addr;
                  cnt_q     <= '0;
                  result_q  <= '0;
                  done_q    <= 1'b0;
                  pass_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  resetl_q  <= 1'b0;
                  hold_q    <= '0;
                  state_q   <= HOLD;
               end
            end
            HOLD: begin
               if (hold_q == HOLD_LAST) begin
                  resetl_q <= 1'b1;
                  state_q  <= RUN;
               end else begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            RUN: begin
               cnt_q <= cnt_d;
               // Completion outranks the watchdog when both fire together.
               if (reached) begin
                  result_q  <= bus.memtoregout;
                  pass_q    <= (bus.memtoregout == exp_q);
                  timeout_q <= 1'b0;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= DONE;
               end else if (wd_hit) begin
                  result_q  <= bus.memtoregout;
                  pass_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.cpu_resetl  = resetl_q;
   assign bus.cpu_startpc = startpc_q;
   assign bus.cpu_ce      = ce;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.pass        = pass_q;
   assign bus.timeout     = timeout_q;
   assign bus.result      = result_q;
   assign bus.cycle_count = cnt_q;
endmodule
